// File: rtl/draw_command_queue_if.sv
// draw_command_queue_if: command-side and DrawMif-side bus of the draw queue.
//   master : producer + DrawMif side (drives commands, flush and ready)
//   slave  : the queue (accepts commands, drives origin/id/draw)
//   cmdX/cmdY/cmdMifId/cmdValid/cmdReady : command push handshake
//   flush                                : drop every queued command
//   xOrigin/yOrigin/mifId/draw           : issued command and start pulse
//   ready                                : DrawMif idle/finished
interface draw_command_queue_if;
  logic [15:0] cmdX;
  logic [15:0] cmdY;
  logic [7:0]  cmdMifId;
  logic        cmdValid;
  logic        cmdReady;
  logic        flush;
  logic [15:0] xOrigin;
  logic [15:0] yOrigin;
  logic [7:0]  mifId;
  logic        draw;
  logic        ready;

  modport master (
    output cmdX, cmdY, cmdMifId, cmdValid, flush, ready,
    input  cmdReady, xOrigin, yOrigin, mifId, draw
  );

  modport slave (
    input  cmdX, cmdY, cmdMifId, cmdValid, flush, ready,
    output cmdReady, xOrigin, yOrigin, mifId, draw
  );
endinterface

// File: rtl/draw_command_queue.sv
// draw_command_queue: buffers draw requests {x, y, id} and issues them to
// DrawMif one at a time, pacing on DrawMif's ready.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : command push / DrawMif issue bus (slave side)
//   count        : occupancy 0..DEPTH
//   empty, full  : count==0, count==DEPTH
//   busy         : a draw is in flight
//   overflow     : sticky, a command arrived while full
module draw_command_queue #(
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  draw_command_queue_if.slave   bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BUSY = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  localparam int                  TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [TW-1:0]       TMO_LAST = TW'(BUSY_TIMEOUT);

  logic [39:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [1:0]            state;
  logic [TW-1:0]         tmo_cnt;
  logic                  push, pop;

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign bus.cmdReady = ~full;
  assign busy         = (state != IDLE);

  // full is the pre-pop value, so a push into a full queue loses even when
  // the same edge issues the head. Flush beats both push and issue.
  assign push = bus.cmdValid & ~full & ~bus.flush;
  assign pop  = (state == IDLE) & ~empty & bus.ready & ~bus.flush;

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {bus.cmdX, bus.cmdY, bus.cmdMifId};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      state       <= IDLE;
      tmo_cnt     <= '0;
      bus.xOrigin <= '0;
      bus.yOrigin <= '0;
      bus.mifId   <= '0;
      bus.draw    <= 1'b0;
    end else begin
      bus.draw <= 1'b0;

      if (bus.cmdValid & full & ~bus.flush) overflow <= 1'b1;

      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      case (state)
        IDLE: begin
          if (pop) begin
            {bus.xOrigin, bus.yOrigin, bus.mifId} <= mem[rd_ptr];
            bus.draw <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAIT_BUSY;
          end
        end
        // DrawMif may finish a trivial draw before we ever see ready drop;
        // give up waiting after BUSY_TIMEOUT cycles and treat it as done.
        WAIT_BUSY: begin
          if (!bus.ready) begin
            state <= WAIT_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt + 1'b1 == TMO_LAST) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (bus.ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_command_queue.sv
module tb_draw_command_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TMO   = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW:0]   count;
  logic          empty, full, busy, overflow;

  draw_command_queue_if bus();

  draw_command_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .BUSY_TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .bus(bus), .count(count),
    .empty(empty), .full(full), .busy(busy), .overflow(overflow)
  );

  always #10 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] exp_q[$];
  logic        ovf_m;
  logic [39:0] last_out;
  logic        prev_draw;
  int          cyc, ndraws, last_draw_cyc, min_gap, last_gap;
  int          rd_mode, busy_len, busy_left, d0;
  logic [39:0] first_cmd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the queue model with what was presented at this edge,
  // check the issue against the model, then advance the DrawMif model.
  task automatic tick();
    logic [39:0] c, got;
    @(posedge clock); #1;
    cyc++;
    if (reset) begin
      exp_q.delete();
      ovf_m    = 1'b0;
      last_out = '0;
    end else if (bus.flush) begin
      exp_q.delete();
    end else if (bus.cmdValid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({bus.cmdX, bus.cmdY, bus.cmdMifId});
      else ovf_m = 1'b1;
    end
    got = {bus.xOrigin, bus.yOrigin, bus.mifId};
    if (bus.draw) begin
      chk("draw_not_back_to_back", prev_draw, 0);
      if (exp_q.size() > 0) c = exp_q.pop_front();
      else c = 'x;
      chk("issued_cmd", got, c);
      last_out = got;
      if (ndraws > 0) begin
        last_gap = cyc - last_draw_cyc;
        if (last_gap < min_gap) min_gap = last_gap;
      end
      last_draw_cyc = cyc;
      ndraws++;
    end else begin
      chk("outputs_held", got, last_out);
    end
    prev_draw = bus.draw;
    chk("count", count, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("full", full, exp_q.size() == DEPTH);
    chk("cmdReady", bus.cmdReady, exp_q.size() != DEPTH);
    chk("overflow", overflow, ovf_m);
    case (rd_mode)
      1: begin
        if (bus.draw) begin
          bus.ready = 1'b0;
          busy_left = busy_len;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) bus.ready = 1'b1;
        end
      end
      2: bus.ready = 1'b1;
      default: ;
    endcase
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [7:0] id);
    bus.cmdX = x; bus.cmdY = y; bus.cmdMifId = id; bus.cmdValid = 1'b1;
    tick();
    bus.cmdValid = 1'b0;
  endtask

  task automatic push_rand();
    push(16'($urandom), 16'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < budget) begin
      tick();
      k++;
    end
    chk("drain_busy", busy, 0);
    chk("drain_count", count, 0);
  endtask

  task automatic wait_draws(input int target, input int budget);
    int k = 0;
    while (ndraws < target && k < budget) begin
      tick();
      k++;
    end
    chk("wait_draws", ndraws >= target, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmdX = '0; bus.cmdY = '0; bus.cmdMifId = '0;
    bus.cmdValid = 1'b0; bus.flush = 1'b0; bus.ready = 1'b1;
    rd_mode = 0; busy_len = 0; busy_left = 0;
    ovf_m = 1'b0; last_out = '0; prev_draw = 1'b0;
    cyc = 0; ndraws = 0; last_draw_cyc = 0; min_gap = 1 << 30; last_gap = 0;

    // reset state
    tick(); tick();
    chk("rst_xOrigin", bus.xOrigin, 0);
    chk("rst_yOrigin", bus.yOrigin, 0);
    chk("rst_mifId", bus.mifId, 0);
    chk("rst_draw", bus.draw, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    reset = 1'b0;

    // three commands, DrawMif busy 100 cycles per draw
    rd_mode = 1; busy_len = 100; bus.ready = 1'b1;
    push(16'd10, 16'd20, 8'd1);
    push(16'd30, 16'd40, 8'd2);
    push(16'd50, 16'd60, 8'd3);
    drain(1000);
    chk("A_draws", ndraws, 3);
    chk("A_gap_ge_100", min_gap >= 100, 1);
    chk("A_empty", empty, 1);

    // ready held low: fill, overflow, then release
    do_reset();
    rd_mode = 0; bus.ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_rand();
      if (i == 7) begin
        chk("B_full_at_8", full, 1);
        chk("B_cmdReady_at_8", bus.cmdReady, 0);
      end
    end
    chk("B_overflow", overflow, 1);
    chk("B_count", count, DEPTH);
    d0 = ndraws;
    rd_mode = 1; busy_len = $urandom_range(2, 6); busy_left = 0; bus.ready = 1'b1;
    drain(500);
    repeat (30) tick();
    chk("B_draws", ndraws - d0, 8);

    // push into a full queue on the issue edge
    do_reset();
    rd_mode = 0; bus.ready = 1'b0;
    repeat (DEPTH) push_rand();
    chk("C_full", full, 1);
    rd_mode = 1; busy_len = 3; busy_left = 0; bus.ready = 1'b1;
    push_rand();
    chk("C_draw", bus.draw, 1);
    chk("C_count", count, DEPTH - 1);
    chk("C_overflow", overflow, 1);
    drain(300);

    // flush during the first draw's wait for completion
    do_reset();
    rd_mode = 1; busy_len = 30; busy_left = 0; bus.ready = 1'b1;
    d0 = ndraws;
    first_cmd = {16'h0123, 16'h0456, 8'h78};
    push(16'h0123, 16'h0456, 8'h78);
    repeat (3) push_rand();
    repeat (4) tick();
    chk("D_busy_before_flush", busy, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("D_count_after_flush", count, 0);
    chk("D_busy_after_flush", busy, 1);
    drain(200);
    repeat (20) tick();
    chk("D_draws", ndraws - d0, 1);
    chk("D_outputs", {bus.xOrigin, bus.yOrigin, bus.mifId}, first_cmd);

    // ready never falls: timeout then next issue
    do_reset();
    rd_mode = 2; bus.ready = 1'b1;
    d0 = ndraws;
    push_rand();
    push_rand();
    wait_draws(d0 + 2, 100);
    chk("E_gap", last_gap, TMO + 1);
    repeat (TMO - 1) tick();
    chk("E_busy_before_timeout", busy, 1);
    tick();
    chk("E_idle_after_timeout", busy, 0);

    // reset while a draw is in flight with 3 queued
    do_reset();
    rd_mode = 1; busy_len = 50; busy_left = 0; bus.ready = 1'b1;
    repeat (4) push_rand();
    repeat (3) tick();
    chk("F_count_before", count, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("F_draw", bus.draw, 0);
    chk("F_count", count, 0);
    chk("F_busy", busy, 0);
    chk("F_xOrigin", bus.xOrigin, 0);
    chk("F_yOrigin", bus.yOrigin, 0);
    chk("F_mifId", bus.mifId, 0);
    chk("F_cmdReady", bus.cmdReady, 1);
    rd_mode = 0; bus.ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/draw_command_queue.md
Name: draw_command_queue

Overview:
- Upstream command stage for DrawMif: buffers draw requests from game/UI logic and issues them one at a time.
- Each request carries an origin and a MIF image ID.
- Drives DrawMif's `xOrigin`/`yOrigin`/`mifId`/`draw` inputs and paces issue on DrawMif's `ready` output.
- Lets producers post several sprites back-to-back without waiting for the LCD.

Parameters:
- DEPTH, 8, number of queued commands; power of two, ≥2.
- ADDR_WIDTH, 3, log2(DEPTH).
- BUSY_TIMEOUT, 15, cycles to wait for `ready` to fall after a `draw` pulse before treating the draw as already complete.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- cmdX  input  16  requested x origin.
- cmdY  input  16  requested y origin.
- cmdMifId  input  8  requested image ID.
- cmdValid  input  1  producer presents a command this cycle.
- cmdReady  output  1  queue can accept; equals ~full.
- flush  input  1  discard all queued (not yet issued) commands.
- xOrigin  output  16  to DrawMif.
- yOrigin  output  16  to DrawMif.
- mifId  output  8  to DrawMif.
- draw  output  1  one-cycle start pulse to DrawMif.
- ready  input  1  DrawMif idle/finished indicator.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- busy  output  1  a draw is in flight (state ≠ IDLE).
- overflow  output  1  sticky; set when cmdValid is asserted while full.

Behaviour:
- Reset values (synchronous reset): `xOrigin`, `yOrigin`, `mifId` = 0; `draw` = 0; `count` = 0; `empty` = 1; `full` = 0; `cmdReady` = 1; `busy` = 0; `overflow` = 0.
  - Reset also clears read/write pointers, state = IDLE, timeout counter = 0.
  - Reset mid-draw abandons tracking of the in-flight draw; queue contents are lost.
- Storage:
  - Circular buffer of DEPTH × 40-bit entries {x,y,id}, write pointer and read pointer ADDR_WIDTH bits, wrapping modulo DEPTH.
  - Count is tracked separately so full and empty are unambiguous.
- Push:
  - Occurs on a clock edge when cmdValid=1 and full=0.
  - The entry is written at the write pointer, and the pointer increments.
  - cmdValid=1 with full=1: command dropped, overflow set to 1 (cleared only by reset).
- Pop:
  - Occurs only at issue (below): head entry latched into xOrigin/yOrigin/mifId, read pointer increments.
  - Simultaneous push and pop in the same cycle leaves count unchanged; both pointers advance.
  - full is evaluated before the pop, so a push into a full queue is rejected even in a pop cycle.
- State machine:
  - IDLE: if empty=0, ready=1 and flush=0, then issue: latch head, pop, draw=1 for exactly this cycle, go to WAIT_BUSY with timeout counter = 0.
  - WAIT_BUSY:
    - draw=0.
    - If ready=0, go to WAIT_DONE.
    - Else increment the timeout counter; when it reaches BUSY_TIMEOUT, go to IDLE.
  - WAIT_DONE: stay while ready=0; on ready=1 go to IDLE.
- Issue cadence:
  - Earliest next issue is the cycle after returning to IDLE, so `draw` is never asserted on two consecutive cycles.
  - Minimum spacing between draw pulses is 3 cycles.
- xOrigin/yOrigin/mifId hold their values from issue until the next issue. They are stable throughout a draw.
- flush:
  - Clears the pointers and count in one cycle.
  - Does not affect the state machine or an in-flight draw, and does not clear overflow.
  - A push in the same cycle as flush is discarded (flush wins); overflow is not set for it.
  - No issue occurs in a flush cycle.
- ready=0 while IDLE (e.g. DrawMif still initialising the LCD after reset): no issue; wait.
- Status outputs are registered-state derived (combinational from count/state), with no extra latency.
- Arithmetic: count is ADDR_WIDTH+1 bits and never wraps; pointers wrap naturally.

Test Plan:
- Reset then push three commands (10,20,id 1), (30,40,id 2), (50,60,id 3) while ready=1:
  - required: three single-cycle draw pulses in FIFO order with matching outputs;
  - a DrawMif model holding ready low 100 cycles per draw gives ≥100-cycle spacing;
  - count reaches 0 and empty=1 at the end.
- Hold ready=0, push 9 commands with DEPTH=8:
  - required: full=1 and cmdReady=0 after the 8th push;
  - the 9th push is dropped and overflow=1;
  - raising ready later issues exactly 8 draws.
- Full queue with ready=1 in IDLE, push in the issue cycle → push rejected, count becomes 7, overflow=1.
- Queue 4 commands, flush during the first draw's WAIT_DONE:
  - required: count=0 next cycle;
  - the in-flight draw completes and outputs are unchanged;
  - no further draw pulses occur.
- Model where ready never falls after draw → return to IDLE after BUSY_TIMEOUT (15) cycles, next queued command issued on the following cycle.
- Assert reset during WAIT_DONE with 3 entries queued → next cycle: draw=0, count=0, busy=0, origins=0, cmdReady=1.
